// File: rtl/cmt_trap_ctrl_pkg.sv
// Shared types for the commit-side trap sequencer: error info record,
// pipeline busy indices and the trap FSM state encoding.
package cmt_trap_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MCAUSE_W = 32;

  localparam int unsigned NUM_PL        = 4;
  localparam int unsigned PL_BUSY_ALU0  = 0;
  localparam int unsigned PL_BUSY_ALU1  = 1;
  localparam int unsigned PL_BUSY_LS    = 2;
  localparam int unsigned PL_BUSY_MULT  = 3;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [MCAUSE_W-1:0] mcause;
    logic [XLEN-1:0]     mtval;
  } cmt_err_info_t;

  localparam cmt_err_info_t NULL_CMT_ERR_INFO = '0;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } trap_state_e;

  // Direct-mode vector: mode bits of mtvec are dropped.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec);
    return {mtvec[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cmt_trap_ctrl.sv
// Trap sequencer behind commit: stall issue, drain pipes, flush, write trap
// CSRs and redirect fetch to the trap vector.
module cmt_trap_ctrl
  import cmt_trap_ctrl_pkg::*;
#(
  parameter int unsigned DrainCntW = 8,
  parameter int unsigned TrapCntW  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmt_err_i,
  input  cmt_err_info_t        cmt_err_info_i,
  input  logic [NUM_PL-1:0]    pl_busy_i,
  input  logic                 lsu_outstanding_i,
  input  logic [XLEN-1:0]      mtvec_i,
  output logic                 issue_stall_o,
  output logic                 cmt_flush_o,
  output logic                 csr_trap_we_o,
  output logic [XLEN-1:0]      csr_mepc_o,
  output logic [MCAUSE_W-1:0]  csr_mcause_o,
  output logic [XLEN-1:0]      csr_mtval_o,
  output logic                 redir_valid_o,
  output logic [XLEN-1:0]      redir_pc_o,
  input  logic                 redir_ready_i,
  output logic                 drain_timeout_o,
  output logic [TrapCntW-1:0]  trap_cnt_o
);

  trap_state_e          state_q, state_d;
  cmt_err_info_t        info_q;
  logic [XLEN-1:0]      target_q;
  logic [DrainCntW-1:0] drain_cnt_q;
  logic                 timeout_q;
  logic [TrapCntW-1:0]  trap_cnt_q;
  logic                 pl_busy, drained, drain_expire;

  assign pl_busy = pl_busy_i[PL_BUSY_ALU0] | pl_busy_i[PL_BUSY_ALU1] |
                   pl_busy_i[PL_BUSY_LS]   | pl_busy_i[PL_BUSY_MULT];
  assign drained = ~pl_busy & ~lsu_outstanding_i;
  // Fires on the cycle the counter would step to all-ones, so DRAIN lasts
  // exactly 2**DrainCntW-1 cycles when the pipes never drain.
  assign drain_expire = (drain_cnt_q == {{(DrainCntW-1){1'b1}}, 1'b0});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cmt_err_i) state_d = DRAIN;
      DRAIN:    if (drained || drain_expire) state_d = FLUSH;
      FLUSH:    state_d = REDIRECT;
      REDIRECT: if (redir_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      info_q   <= NULL_CMT_ERR_INFO;
      target_q <= '0;
    end else if (state_q == IDLE && cmt_err_i) begin
      info_q   <= cmt_err_info_i;
      target_q <= trap_target(mtvec_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (state_q == DRAIN && state_d == DRAIN) drain_cnt_q <= drain_cnt_q + 1'b1;
      else                                      drain_cnt_q <= '0;
      if (state_q == DRAIN && !drained && drain_expire) timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   trap_cnt_q <= '0;
    else if (state_q == FLUSH && trap_cnt_q != '1) trap_cnt_q <= trap_cnt_q + 1'b1;
  end

  assign issue_stall_o   = (state_q != IDLE);
  assign cmt_flush_o     = (state_q == FLUSH);
  assign csr_trap_we_o   = (state_q == FLUSH);
  assign redir_valid_o   = (state_q == REDIRECT);
  assign redir_pc_o      = target_q;
  assign csr_mepc_o      = info_q.pc;
  assign csr_mcause_o    = info_q.mcause;
  assign csr_mtval_o     = info_q.mtval;
  assign drain_timeout_o = timeout_q;
  assign trap_cnt_o      = trap_cnt_q;

endmodule

// File: tb/tb_cmt_trap_ctrl.sv
// Self-checking bench for cmt_trap_ctrl: directed table, corner sequences
// and randomized traffic against a behavioural trap model.
module tb_cmt_trap_ctrl;
  import cmt_trap_ctrl_pkg::*;

  logic          clk, rst_n, err, lsu, ready;
  cmt_err_info_t info;
  logic [3:0]    busy;
  logic [31:0]   mtvec;

  logic          stall, flush, we, rvalid, tmo;
  logic [31:0]   mepc, mcause, mtval, rpc;
  logic [15:0]   tcnt;

  logic          stall2, flush2, we2, rvalid2, tmo2;
  logic [31:0]   mepc2, mcause2, mtval2, rpc2;
  logic [2:0]    tcnt2;

  int tests = 0, fails = 0;

  cmt_trap_ctrl #(.DrainCntW(8), .TrapCntW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmt_err_i(err), .cmt_err_info_i(info),
    .pl_busy_i(busy), .lsu_outstanding_i(lsu), .mtvec_i(mtvec),
    .issue_stall_o(stall), .cmt_flush_o(flush), .csr_trap_we_o(we),
    .csr_mepc_o(mepc), .csr_mcause_o(mcause), .csr_mtval_o(mtval),
    .redir_valid_o(rvalid), .redir_pc_o(rpc), .redir_ready_i(ready),
    .drain_timeout_o(tmo), .trap_cnt_o(tcnt));

  // Narrow trap counter instance so saturation is reachable in a short run.
  cmt_trap_ctrl #(.DrainCntW(8), .TrapCntW(3)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .cmt_err_i(err), .cmt_err_info_i(info),
    .pl_busy_i(busy), .lsu_outstanding_i(lsu), .mtvec_i(mtvec),
    .issue_stall_o(stall2), .cmt_flush_o(flush2), .csr_trap_we_o(we2),
    .csr_mepc_o(mepc2), .csr_mcause_o(mcause2), .csr_mtval_o(mtval2),
    .redir_valid_o(rvalid2), .redir_pc_o(rpc2), .redir_ready_i(ready),
    .drain_timeout_o(tmo2), .trap_cnt_o(tcnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 waiting for drain, 2 flush, 3 redirect.
  int          m_ph, m_wait, m_traps;
  logic [31:0] m_pc, m_cause, m_tval, m_tgt;
  logic        m_to;

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_traps = 0; m_to = 1'b0;
    m_pc = 0; m_cause = 0; m_tval = 0; m_tgt = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: if (err) begin
        m_pc = info.pc; m_cause = info.mcause; m_tval = info.mtval;
        m_tgt = mtvec & 32'hFFFF_FFFC;
        m_wait = 0; m_ph = 1;
      end
      1: if (busy == 4'd0 && !lsu) m_ph = 2;
         else begin
           m_wait++;
           if (m_wait == 255) begin m_to = 1'b1; m_ph = 2; end
         end
      2: begin m_traps++; m_ph = 3; end
      default: if (ready) m_ph = 0;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("issue_stall", stall, m_ph != 0);
    chk("cmt_flush", flush, m_ph == 2);
    chk("csr_trap_we", we, m_ph == 2);
    chk("redir_valid", rvalid, m_ph == 3);
    chk("redir_pc", rpc, m_tgt);
    chk("csr_mepc", mepc, m_pc);
    chk("csr_mcause", mcause, m_cause);
    chk("csr_mtval", mtval, m_tval);
    chk("drain_timeout", tmo, m_to);
    chk("trap_cnt", tcnt, (m_traps > 65535) ? 65535 : m_traps);
    chk("trap_cnt_sat", tcnt2, (m_traps > 7) ? 7 : m_traps);
    chk("sat_flush", flush2, m_ph == 2);
    chk("sat_redir_valid", rvalid2, m_ph == 3);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic       err;
    logic [3:0] busy;
    logic       lsu;
    logic       ready;
    logic       e_stall;
    logic       e_flush;
    logic       e_valid;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n, nflush;
    logic [31:0] pc_hold;

    tbl[0] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; err = 1'b0; busy = 4'h0; lsu = 1'b0; ready = 1'b0;
    mtvec = 32'h0; info = NULL_CMT_ERR_INFO;
    #1;
    model_reset();
    check_all();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Error with pipes idle: minimum latency path.
    info = '{pc: 32'h100, mcause: 32'd5, mtval: 32'h2000};
    mtvec = 32'h8001;
    for (int i = 0; i < 5; i++) begin
      err = tbl[i].err; busy = tbl[i].busy; lsu = tbl[i].lsu; ready = tbl[i].ready;
      cycle();
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_flush", i), flush, tbl[i].e_flush);
      chk($sformatf("tbl%0d_valid", i), rvalid, tbl[i].e_valid);
      if (i == 0) mtvec = 32'hDEAD_BEE7;
      if (i == 1) begin
        chk("tbl_mepc", mepc, 32'h100);
        chk("tbl_mcause", mcause, 32'd5);
        chk("tbl_mtval", mtval, 32'h2000);
        chk("tbl_we", we, 1'b1);
      end
      if (i == 2) chk("tbl_redir_pc", rpc, 32'h8000);
    end

    // Drain wait on the load/store pipe.
    info = '{pc: 32'h204, mcause: 32'd2, mtval: 32'h0};
    err = 1'b1; busy = 4'b0100; ready = 1'b1;
    cycle();
    err = 1'b0;
    nflush = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("drain_stall", stall, 1'b1);
      if (flush) nflush++;
    end
    busy = 4'b0000;
    cycle();
    chk("drain_flush_after_clear", flush, 1'b1);
    nflush++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (flush) nflush++;
    end
    chk("drain_flush_once", nflush, 1);

    // Timeout with LSU never draining.
    err = 1'b1; lsu = 1'b1;
    cycle();
    err = 1'b0;
    n = 0;
    while (!flush && n < 400) begin
      cycle();
      n++;
    end
    chk("timeout_drain_cycles", n, 255);
    chk("timeout_flag", tmo, 1'b1);
    lsu = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("timeout_sticky", tmo, 1'b1);

    // Redirect backpressure; mtvec churn must not disturb the target.
    mtvec = 32'h0000_4002; ready = 1'b0; err = 1'b1;
    cycle();
    err = 1'b0;
    cycle();
    cycle();
    chk("bp_valid_first", rvalid, 1'b1);
    pc_hold = rpc;
    chk("bp_target", pc_hold, 32'h4000);
    for (int i = 0; i < 5; i++) begin
      mtvec = $urandom;
      cycle();
      chk("bp_valid_hold", rvalid, 1'b1);
      chk("bp_pc_hold", rpc, 32'h4000);
    end
    ready = 1'b1;
    cycle();
    chk("bp_idle_after_ready", rvalid, 1'b0);
    chk("bp_stall_clear", stall, 1'b0);

    // Back-to-back: sticky error held through the whole first trap.
    err = 1'b1; nflush = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (flush) nflush++;
    end
    err = 1'b0;
    cycle();
    chk("b2b_flushes", nflush, 2);
    chk("b2b_trap_cnt", tcnt, 32'd6);

    // Reset in the middle of DRAIN aborts the trap.
    err = 1'b1; busy = 4'b1000;
    cycle();
    err = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_stall", stall, 1'b0);
    chk("rst_trap_cnt", tcnt, 32'd0);
    chk("rst_mepc", mepc, 32'd0);
    cycle();
    rst_n = 1'b1; busy = 4'b0000;
    nflush = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (flush || we || rvalid) nflush++;
    end
    chk("rst_no_flush", nflush, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      err   = ($urandom_range(0, 5) == 0);
      busy  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      lsu   = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 2) != 0);
      mtvec = $urandom;
      info  = '{pc: $urandom, mcause: $urandom, mtval: $urandom};
      cycle();
    end

    // Drive enough traps to saturate the narrow counter.
    err = 1'b1; busy = 4'h0; lsu = 1'b0; ready = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    err = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("sat_hold_max", tcnt2, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmt_trap_ctrl.md
Name: cmt_trap_ctrl

Overview:
Trap sequencer behind the commit stage. It reacts to the committer's sticky error flag and stalls issue. It then waits for the ALU, load/store and multiply pipelines and the LSU bus to drain. Next it flushes the committer and issuer, writes the trap CSRs (mepc/mcause/mtval), and redirects fetch to the trap vector through a valid/ready handshake. It is the single owner of the commit-flush signal.

Parameters:
DrainCntW, 8, width of the drain-timeout counter; timeout fires after 2**DrainCntW-1 cycles in DRAIN.
TrapCntW, 16, width of the saturating trap counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmt_err_i  in  1  sticky commit error from committer
cmt_err_info_i  in  cmt_err_info_t  {pc, mcause, mtval} of the faulting instruction
pl_busy_i  in  4  {mult, ls, alu1, alu0}, pipeline holds an in-flight instruction
lsu_outstanding_i  in  1  LSU bus transaction pending
mtvec_i  in  32  trap vector base
issue_stall_o  out  1  block issuer from dispatching
cmt_flush_o  out  1  flush pulse to committer, issuer and scoreboard FIFO
csr_trap_we_o  out  1  one-cycle CSR write strobe
csr_mepc_o  out  32  latched pc
csr_mcause_o  out  mcause width  latched mcause
csr_mtval_o  out  32  latched mtval
redir_valid_o  out  1  fetch redirect request
redir_pc_o  out  32  redirect target
redir_ready_i  in  1  fetch accepts redirect
drain_timeout_o  out  1  sticky; drain ended by timeout
trap_cnt_o  out  TrapCntW  number of traps taken, saturating

Behaviour:
- Reset: state IDLE. All outputs 0. Latched info = NULL_CMT_ERR_INFO. Counters 0. drain_timeout_o = 0.
- FSM is IDLE -> DRAIN -> FLUSH -> REDIRECT -> IDLE. State register only; outputs decode from registered state.
- IDLE:
  - If cmt_err_i = 1, latch cmt_err_info_i and target = {mtvec_i[31:2], 2'b00}, then go to DRAIN.
  - Else stay in IDLE.
- DRAIN:
  - drained = (pl_busy_i == 0) & ~lsu_outstanding_i.
  - If drained, go to FLUSH.
  - Else drain_cnt increments. When drain_cnt reaches all-ones, set drain_timeout_o and go to FLUSH.
  - drain_cnt clears on leaving DRAIN.
- FLUSH: exactly one cycle.
  - cmt_flush_o = 1 and csr_trap_we_o = 1.
  - trap_cnt increments; it holds at all-ones.
  - Go to REDIRECT.
- REDIRECT:
  - redir_valid_o = 1, with redir_pc_o stable.
  - If redir_ready_i = 1, go to IDLE next cycle.
  - Valid never drops without ready.
- issue_stall_o = (state != IDLE); this includes REDIRECT.
- Minimum latency:
  - cmt_err_i seen in cycle N gives DRAIN at N+1.
  - If already drained: FLUSH at N+2, redir_valid at N+3.
  - If ready is also high at N+3: IDLE at N+4.
- csr_* outputs always show the latched values; consumers use them only with the strobe.
- cmt_err_i outside IDLE is ignored. The committer clears its flag on flush.
- If cmt_err_i is still 1 in the IDLE cycle after REDIRECT, it is a new trap and is processed normally.
- mtvec_i changes after the latch do not affect the target.
- Reset mid-sequence aborts it: no flush, CSR or redirect is emitted afterwards.
- drain_timeout_o clears only on reset.

Decomposition:
- super_pkg gains:
  - trap_state_e (IDLE, DRAIN, FLUSH, REDIRECT);
  - NUM_PL = 4 and PL_BUSY index constants;
  - reuse of cmt_err_info_t and NULL_CMT_ERR_INFO.
- No sub-module. The saturating counter is an inline always_ff.

Test Plan:
- Error with pipes idle: cmt_err_i=1 at N with info {pc=0x100, mcause=5, mtval=0x2000}, mtvec=0x8001, redir_ready=1 -> flush and CSR strobe at N+2 with mepc=0x100; redir_pc=0x8000 at N+3; IDLE at N+4.
- Drain wait: pl_busy=4'b0100 for 10 cycles after the error -> cmt_flush_o pulses exactly once, one cycle after busy clears; issue_stall_o is high the whole time.
- Timeout: lsu_outstanding held at 1 -> FLUSH after 255 DRAIN cycles; drain_timeout_o=1 and stays 1.
- Redirect backpressure: redir_ready=0 for 5 cycles -> redir_valid and redir_pc stay stable; IDLE the cycle after ready.
- Back-to-back traps and mid-sequence reset: second error right after return to IDLE -> trap_cnt=2. rst_ni low during DRAIN -> all outputs 0 and no flush.
- Saturation: force trap_cnt to 0xFFFF and take a trap -> trap_cnt stays 0xFFFF.
